// File: rtl/fetch_unit.sv
// fetch_unit: loads the reset vector, fetches opcode plus 0..2 operand bytes, and hands
// them to the decoder. Define FETCH_WATCHDOG_EN to build the ISSUE-state watchdog.
module fetch_unit #(
   parameter int                    REG_WIDTH    = 8,
   parameter int                    ADDR_WIDTH   = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
   parameter int                    WDT_LIMIT    = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [REG_WIDTH-1:0]  mem_rdata,
   input  logic                  mem_valid,
   output logic [REG_WIDTH-1:0]  instruction_out,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  instruction_ready,
   input  logic                  instruction_done,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_load_value,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  fetch_error
);

   typedef enum logic [2:0] {VEC_LO, VEC_HI, OPC, OPR_LO, OPR_HI, ISSUE} state_t;

   state_t                state, state_next;
   logic [REG_WIDTH-1:0]  vec_lo;
   logic [1:0]            opr_len;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_done;
   logic                  wdt_expire;

   // Operand byte count from the cc/bbb opcode fields.
   function automatic logic [1:0] operand_len(input logic [REG_WIDTH-1:0] opc);
      logic [1:0] cc;
      logic [2:0] bbb;
      cc  = opc[1:0];
      bbb = opc[4:2];
      if (opc == REG_WIDTH'(8'h00) || opc == REG_WIDTH'(8'h40) || opc == REG_WIDTH'(8'h60))
         return 2'd0;
      else if (bbb == 3'b011 || bbb == 3'b111 || (bbb == 3'b110 && cc == 2'b01))
         return 2'd2;
      else if ((cc == 2'b00 || cc == 2'b10) && (bbb == 3'b010 || bbb == 3'b110))
         return 2'd0;
      else
         return 2'd1;
   endfunction

   assign rd_done = mem_rd && mem_valid;

   always_comb begin
      rd_addr = pc;
      if (state == VEC_LO)
         rd_addr = RESET_VECTOR;
      else if (state == VEC_HI)
         rd_addr = RESET_VECTOR + ADDR_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= VEC_LO;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         VEC_LO:  if (rd_done) state_next = VEC_HI;
         VEC_HI:  if (rd_done) state_next = OPC;
         OPC:     if (rd_done) state_next = (operand_len(mem_rdata) == 2'd0) ? ISSUE : OPR_LO;
         OPR_LO:  if (rd_done) state_next = (opr_len == 2'd2) ? OPR_HI : ISSUE;
         OPR_HI:  if (rd_done) state_next = ISSUE;
         ISSUE:   if (instruction_done || wdt_expire) state_next = OPC;
         default: state_next = VEC_LO;
      endcase
   end

   always_comb begin
      instruction_ready = (state == ISSUE);
   end

   // Every read state opens with one mem_rd=0 cycle, so mem_rd always drops after a capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd          <= 1'b0;
         mem_addr        <= '0;
         pc              <= '0;
         instruction_out <= '0;
         addr_out        <= '0;
         vec_lo          <= '0;
         opr_len         <= '0;
      end else if (state == ISSUE) begin
         mem_rd <= 1'b0;
         if (instruction_done && pc_load)
            pc <= pc_load_value;
      end else if (!mem_rd) begin
         mem_rd   <= 1'b1;
         mem_addr <= rd_addr;
      end else if (mem_valid) begin
         mem_rd <= 1'b0;
         case (state)
            VEC_LO: vec_lo <= mem_rdata;
            VEC_HI: pc     <= ADDR_WIDTH'({mem_rdata, vec_lo});
            OPC: begin
               instruction_out <= mem_rdata;
               opr_len         <= operand_len(mem_rdata);
               addr_out        <= '0;
               pc              <= pc + ADDR_WIDTH'(1);
            end
            OPR_LO: begin
               addr_out <= ADDR_WIDTH'(mem_rdata);
               pc       <= pc + ADDR_WIDTH'(1);
            end
            OPR_HI: begin
               addr_out <= ADDR_WIDTH'({mem_rdata, addr_out[REG_WIDTH-1:0]});
               pc       <= pc + ADDR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_WATCHDOG_EN
   logic [7:0] wdt_cnt;

   assign wdt_expire = (state == ISSUE) && !instruction_done && (wdt_cnt == 8'(WDT_LIMIT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdt_cnt     <= '0;
         fetch_error <= 1'b0;
      end else begin
         fetch_error <= wdt_expire;
         if (state != ISSUE)
            wdt_cnt <= '0;
         else if (!instruction_done)
            wdt_cnt <= wdt_cnt + 8'd1;
      end
   end
`else
   assign wdt_expire  = 1'b0;
   assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency byte memory responder.
// Watchdog scenario is built when FETCH_WATCHDOG_EN is defined.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_valid;
   logic [7:0]  instruction_out;
   logic [15:0] addr_out;
   logic        instruction_ready;
   logic        instruction_done;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] pc;
   logic        fetch_error;

   logic [7:0]  mem [0:65535];
   logic [15:0] read_log [$];
   int unsigned rd_delay;
   bit          proto_err;
   bit          addr_err;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .REG_WIDTH   (8),
      .ADDR_WIDTH  (16),
      .RESET_VECTOR(16'hFFFC),
      .WDT_LIMIT   (10)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mem_addr         (mem_addr),
      .mem_rd           (mem_rd),
      .mem_rdata        (mem_rdata),
      .mem_valid        (mem_valid),
      .instruction_out  (instruction_out),
      .addr_out         (addr_out),
      .instruction_ready(instruction_ready),
      .instruction_done (instruction_done),
      .pc_load          (pc_load),
      .pc_load_value    (pc_load_value),
      .pc               (pc),
      .fetch_error      (fetch_error)
   );

   // Memory responder: logs each request, checks address hold and mem_rd drop after data.
   initial begin
      int unsigned wait_cnt;
      bit          in_req;
      logic [15:0] req_addr;
      mem_valid = 1'b0;
      mem_rdata = '0;
      wait_cnt  = 0;
      in_req    = 1'b0;
      req_addr  = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mem_valid = 1'b0;
            wait_cnt  = 0;
            in_req    = 1'b0;
         end else if (mem_valid) begin
            mem_valid = 1'b0;
            if (mem_rd) proto_err = 1'b1;
         end else if (mem_rd) begin
            if (!in_req) begin
               in_req   = 1'b1;
               req_addr = mem_addr;
               read_log.push_back(mem_addr);
            end else if (mem_addr !== req_addr) begin
               addr_err = 1'b1;
            end
            if (wait_cnt == rd_delay) begin
               mem_valid = 1'b1;
               mem_rdata = mem[mem_addr];
               wait_cnt  = 0;
               in_req    = 1'b0;
            end else begin
               wait_cnt = wait_cnt + 1;
            end
         end else begin
            wait_cnt = 0;
            in_req   = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] log_at(input int i);
      if (i >= 0 && i < read_log.size()) return read_log[i];
      return 'x;
   endfunction

   task automatic hold_reset(input int unsigned delay);
      reset_n          = 1'b0;
      instruction_done = 1'b0;
      pc_load          = 1'b0;
      pc_load_value    = '0;
      rd_delay         = delay;
      for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'hEA;
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h80;
      @(posedge clk); #1;
   endtask

   task automatic release_reset();
      read_log.delete();
      proto_err = 1'b0;
      addr_err  = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_ready(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(posedge clk); #1;
         if (instruction_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      hold_reset(0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
      n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
      n_checks++; if (instruction_out !== 8'h00) begin n_fail++; $display("FAIL reset_instr got=%h exp=00", instruction_out); end
      n_checks++; if (addr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_addr_out got=%h exp=0000", addr_out); end
      n_checks++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", instruction_ready); end
      n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_error got=%b exp=0", fetch_error); end
   endtask

   task automatic test_lda_imm();
      bit ok;
      hold_reset(0);
      mem[16'h8000] = 8'hA9;
      mem[16'h8001] = 8'h42;
      release_reset();
      wait_ready(60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lda_ready_timeout got=%b exp=1", ok); end
      n_checks++; if (instruction_out !== 8'hA9) begin n_fail++; $display("FAIL lda_instr got=%h exp=a9", instruction_out); end
      n_checks++; if (addr_out !== 16'h0042) begin n_fail++; $display("FAIL lda_addr_out got=%h exp=0042", addr_out); end
      n_checks++; if (pc !== 16'h8002) begin n_fail++; $display("FAIL lda_pc got=%h exp=8002", pc); end
      n_checks++; if (read_log.size() !== 4) begin n_fail++; $display("FAIL lda_reads got=%0d exp=4", read_log.size()); end
      n_checks++; if (log_at(0) !== 16'hFFFC) begin n_fail++; $display("FAIL lda_vec_lo_addr got=%h exp=fffc", log_at(0)); end
      n_checks++; if (log_at(1) !== 16'hFFFD) begin n_fail++; $display("FAIL lda_vec_hi_addr got=%h exp=fffd", log_at(1)); end
      n_checks++; if (log_at(2) !== 16'h8000) begin n_fail++; $display("FAIL lda_opc_addr got=%h exp=8000", log_at(2)); end
      n_checks++; if (log_at(3) !== 16'h8001) begin n_fail++; $display("FAIL lda_opr_addr got=%h exp=8001", log_at(3)); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL lda_rd_after_valid got=%b exp=0", proto_err); end
   endtask

   task automatic test_sta_abs_slow();
      bit ok;
      hold_reset(3);
      mem[16'h8000] = 8'h8D;
      mem[16'h8001] = 8'h34;
      mem[16'h8002] = 8'h12;
      release_reset();
      wait_ready(150, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sta_ready_timeout got=%b exp=1", ok); end
      n_checks++; if (instruction_out !== 8'h8D) begin n_fail++; $display("FAIL sta_instr got=%h exp=8d", instruction_out); end
      n_checks++; if (addr_out !== 16'h1234) begin n_fail++; $display("FAIL sta_addr_out got=%h exp=1234", addr_out); end
      n_checks++; if (pc !== 16'h8003) begin n_fail++; $display("FAIL sta_pc got=%h exp=8003", pc); end
      n_checks++; if (read_log.size() !== 5) begin n_fail++; $display("FAIL sta_reads got=%0d exp=5", read_log.size()); end
      n_checks++; if (log_at(4) !== 16'h8002) begin n_fail++; $display("FAIL sta_opr_hi_addr got=%h exp=8002", log_at(4)); end
      n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL sta_addr_hold got=%b exp=0", addr_err); end
      n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL sta_rd_after_valid got=%b exp=0", proto_err); end
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (addr_out !== 16'h1234) begin n_fail++; $display("FAIL sta_addr_out_stable got=%h exp=1234", addr_out); end
   endtask

   task automatic test_implied_done_held();
      bit ok;
      hold_reset(0);
      mem[16'h8000] = 8'h0A;
      release_reset();
      wait_ready(60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL asl_ready_timeout got=%b exp=1", ok); end
      n_checks++; if (instruction_out !== 8'h0A) begin n_fail++; $display("FAIL asl_instr got=%h exp=0a", instruction_out); end
      n_checks++; if (addr_out !== 16'h0000) begin n_fail++; $display("FAIL asl_addr_out got=%h exp=0000", addr_out); end
      n_checks++; if (pc !== 16'h8001) begin n_fail++; $display("FAIL asl_pc got=%h exp=8001", pc); end
      n_checks++; if (read_log.size() !== 3) begin n_fail++; $display("FAIL asl_reads got=%0d exp=3", read_log.size()); end
      instruction_done = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL asl_ready_gap got=%b exp=0", instruction_ready); end
      @(posedge clk); #1;
      instruction_done = 1'b0;
      wait_ready(60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL asl_next_timeout got=%b exp=1", ok); end
      n_checks++; if (instruction_out !== 8'hEA) begin n_fail++; $display("FAIL asl_next_instr got=%h exp=ea", instruction_out); end
      n_checks++; if (read_log.size() !== 4) begin n_fail++; $display("FAIL asl_single_fetch got=%0d exp=4", read_log.size()); end
      n_checks++; if (log_at(3) !== 16'h8001) begin n_fail++; $display("FAIL asl_next_addr got=%h exp=8001", log_at(3)); end
      n_checks++; if (pc !== 16'h8002) begin n_fail++; $display("FAIL asl_next_pc got=%h exp=8002", pc); end
   endtask

   task automatic test_pc_load();
      bit ok;
      hold_reset(0);
      release_reset();
      pc_load          = 1'b1;
      pc_load_value    = 16'h1234;
      instruction_done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pc_load          = 1'b0;
      instruction_done = 1'b0;
      wait_ready(60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL jmp_ready_timeout got=%b exp=1", ok); end
      n_checks++; if (pc !== 16'h8001) begin n_fail++; $display("FAIL jmp_ignored_load_pc got=%h exp=8001", pc); end
      instruction_done = 1'b1;
      pc_load          = 1'b1;
      pc_load_value    = 16'hC000;
      @(posedge clk); #1;
      instruction_done = 1'b0;
      pc_load          = 1'b0;
      n_checks++; if (pc !== 16'hC000) begin n_fail++; $display("FAIL jmp_pc_loaded got=%h exp=c000", pc); end
      wait_ready(60, ok);
      n_checks++; if (log_at(3) !== 16'hC000) begin n_fail++; $display("FAIL jmp_fetch_addr got=%h exp=c000", log_at(3)); end
      n_checks++; if (pc !== 16'hC001) begin n_fail++; $display("FAIL jmp_next_pc got=%h exp=c001", pc); end
   endtask

   task automatic test_wrap_and_async_reset();
      bit ok;
      bit found;
      hold_reset(3);
      mem[16'hFFFF] = 8'hEA;
      mem[16'h0000] = 8'h8D;
      mem[16'h0001] = 8'h34;
      mem[16'h0002] = 8'h12;
      release_reset();
      wait_ready(150, ok);
      instruction_done = 1'b1;
      pc_load          = 1'b1;
      pc_load_value    = 16'hFFFF;
      @(posedge clk); #1;
      instruction_done = 1'b0;
      pc_load          = 1'b0;
      wait_ready(150, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_ready_timeout got=%b exp=1", ok); end
      n_checks++; if (log_at(3) !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_fetch_addr got=%h exp=ffff", log_at(3)); end
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
      instruction_done = 1'b1;
      @(posedge clk); #1;
      instruction_done = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (mem_rd && mem_addr == 16'h0002) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL wrap_opr_hi_timeout got=%b exp=1", found); end
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL areset_mem_rd got=%b exp=0", mem_rd); end
      n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL areset_mem_addr got=%h exp=0000", mem_addr); end
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL areset_pc got=%h exp=0000", pc); end
      n_checks++; if (instruction_out !== 8'h00) begin n_fail++; $display("FAIL areset_instr got=%h exp=00", instruction_out); end
      n_checks++; if (addr_out !== 16'h0000) begin n_fail++; $display("FAIL areset_addr_out got=%h exp=0000", addr_out); end
      n_checks++; if (instruction_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready got=%b exp=0", instruction_ready); end
      release_reset();
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (read_log.size() != 0) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++; if (log_at(0) !== 16'hFFFC) begin n_fail++; $display("FAIL areset_restart_addr got=%h exp=fffc found=%b", log_at(0), found); end
   endtask

`ifdef FETCH_WATCHDOG_EN
   task automatic test_watchdog();
      bit ok;
      int issue_cycles;
      hold_reset(0);
      release_reset();
      wait_ready(60, ok);
      issue_cycles = 1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (!instruction_ready) break;
         issue_cycles++;
      end
      n_checks++; if (issue_cycles !== 10) begin n_fail++; $display("FAIL wdt_issue_cycles got=%0d exp=10", issue_cycles); end
      n_checks++; if (fetch_error !== 1'b1) begin n_fail++; $display("FAIL wdt_error_pulse got=%b exp=1", fetch_error); end
      n_checks++; if (pc !== 16'h8001) begin n_fail++; $display("FAIL wdt_pc_kept got=%h exp=8001", pc); end
      @(posedge clk); #1;
      n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL wdt_error_width got=%b exp=0", fetch_error); end
      wait_ready(60, ok);
      n_checks++; if (log_at(3) !== 16'h8001) begin n_fail++; $display("FAIL wdt_refetch_addr got=%h exp=8001", log_at(3)); end
   endtask
`else
   task automatic test_issue_hold();
      bit ok;
      int bad;
      hold_reset(0);
      release_reset();
      wait_ready(60, ok);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!instruction_ready || fetch_error) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_issue_lost got=%0d exp=0", bad); end
      n_checks++; if (read_log.size() !== 3) begin n_fail++; $display("FAIL hold_extra_reads got=%0d exp=3", read_log.size()); end
   endtask
`endif

   initial begin
      reset_n          = 1'b0;
      instruction_done = 1'b0;
      pc_load          = 1'b0;
      pc_load_value    = '0;
      rd_delay         = 0;
      proto_err        = 1'b0;
      addr_err         = 1'b0;
      test_reset();
      test_lda_imm();
      test_sta_abs_slow();
      test_implied_done_held();
      test_pc_load();
      test_wrap_and_async_reset();
`ifdef FETCH_WATCHDOG_EN
      test_watchdog();
`else
      test_issue_hold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data/opcode width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width.
REQ-003 SHALL have parameter RESET_VECTOR, default 16'hFFFC, address of the low byte of the reset vector.
REQ-004 SHALL have parameter WDT_LIMIT, default 255, watchdog limit in cycles; only used under FETCH_WATCHDOG_EN.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all state on its rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port mem_addr  out  ADDR_WIDTH  memory read address.
REQ-008 SHALL have port mem_rd  out  1  read request.
REQ-009 SHALL have port mem_rdata  in  REG_WIDTH  read data, valid with mem_valid.
REQ-010 SHALL have port mem_valid  in  1  read completed this cycle.
REQ-011 SHALL have port instruction_out  out  REG_WIDTH  opcode to the decoder.
REQ-012 SHALL have port addr_out  out  ADDR_WIDTH  assembled operand.
REQ-013 SHALL have port instruction_ready  out  1  opcode/operand valid; decoder acts on its rising edge.
REQ-014 SHALL have port instruction_done  in  1  decoder finished the current instruction.
REQ-015 SHALL have port pc_load  in  1  jump/branch request, qualified by instruction_done.
REQ-016 SHALL have port pc_load_value  in  ADDR_WIDTH  new PC.
REQ-017 SHALL have port pc  out  ADDR_WIDTH  current program counter.
REQ-018 SHALL have port fetch_error  out  1  watchdog expiry pulse.

Function
REQ-019 SHALL implement states VEC_LO, VEC_HI, OPC, OPR_LO, OPR_HI, ISSUE.
REQ-020 Each memory read SHALL hold mem_rd=1 with mem_addr stable until a cycle with mem_valid=1; data is captured in that cycle and mem_rd SHALL be 0 in the following cycle.
REQ-021 VEC_LO SHALL read RESET_VECTOR, then VEC_HI SHALL read RESET_VECTOR+1; pc SHALL become {hi,lo}, then OPC.
REQ-022 OPC SHALL read at pc, latch instruction_out, increment pc, and compute operand length L from opcode bits cc=[1:0], bbb=[4:2].
REQ-023 L SHALL be 2 when bbb is 011 or 111, or when bbb=110 and cc=01.
REQ-024 L SHALL be 0 when cc is 00 or 10 and bbb is 010 or 110, and also for opcodes 8'h00, 8'h40 and 8'h60.
REQ-025 L SHALL be 1 for every other opcode.
REQ-026 OPC SHALL go to ISSUE if L=0, else to OPR_LO.
REQ-027 OPR_LO SHALL read the low byte and increment pc, then go to OPR_HI if L=2, else to ISSUE.
REQ-028 OPR_HI SHALL read the high byte, increment pc, then go to ISSUE.
REQ-029 addr_out SHALL be {hi,lo} when L=2, {8'h00,lo} when L=1, and 0 when L=0; it SHALL be stable throughout ISSUE.
REQ-030 instruction_ready SHALL be 1 exactly while in ISSUE and 0 in every other state, giving at least one low cycle between instructions.
REQ-031 In ISSUE with instruction_done=1, the block SHALL go to OPC next cycle.
REQ-032 If pc_load=1 in that same cycle, pc SHALL take pc_load_value; otherwise pc is unchanged.
REQ-033 pc_load SHALL be ignored in every other state or cycle.
REQ-034 pc SHALL wrap from all-ones to 0 on increment.
REQ-035 instruction_done outside ISSUE SHALL be ignored.

Reset
REQ-036 While reset_n=0, the block SHALL set state=VEC_LO, pc=0, mem_rd=0, mem_addr=0, instruction_out=0, addr_out=0, instruction_ready=0, fetch_error=0 and watchdog count=0, immediately and independent of clk.
REQ-037 Reset asserted mid-read or mid-ISSUE SHALL abandon the operation; after release, the block SHALL restart at VEC_LO on the first clock edge.

Configuration
REQ-038 With macro FETCH_WATCHDOG_EN defined, an 8-bit counter SHALL clear on ISSUE entry and increment each ISSUE cycle without instruction_done.
REQ-039 When that counter reaches WDT_LIMIT, the block SHALL pulse fetch_error for 1 cycle, drop instruction_ready and go to OPC with pc unchanged.
REQ-040 Without FETCH_WATCHDOG_EN, ISSUE SHALL wait indefinitely, no counter logic SHALL be built, and fetch_error SHALL be tied 0.

Verification
REQ-041 Reset release with mem[FFFC]=00, mem[FFFD]=80, mem[8000]=A9 (LDA imm), mem[8001]=42 -> instruction_out=A9, addr_out=0042, instruction_ready=1, pc=8002.
REQ-042 mem[8000]=8D (STA abs), 34, 12 with mem_valid delayed 3 cycles per read -> mem_addr held per read, addr_out=1234, pc=8003.
REQ-043 mem[8000]=0A (ASL A) -> L=0, instruction_ready after the opcode read, addr_out=0000, pc=8001; done held 2 cycles -> next fetch at 8001 only.
REQ-044 Done with pc_load=1, pc_load_value=C000 -> next mem_addr=C000; pc_load pulsed outside ISSUE -> no effect.
REQ-045 pc=FFFF fetching EA -> pc wraps to 0000; reset_n dropped during OPR_HI -> all outputs 0 asynchronously, and VEC_LO reads FFFC after release.
REQ-046 FETCH_WATCHDOG_EN, WDT_LIMIT=10, done never asserted -> fetch_error pulse after 10 ISSUE cycles and next opcode fetched from the current pc.
